// File: rtl/writeback_arbiter_pkg.sv
// Shared core definitions for the writeback path: requester count and fixed requester indices.
// Grant policy is selected by WB_ROUND_ROBIN_EN (round-robin when defined, fixed priority otherwise).
package writeback_arbiter_pkg;

  localparam int NUM_REQ_DEF = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

  // Index width for a requester number; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_wb_rr_arbiter.sv
// Writeback grant logic. WB_ROUND_ROBIN_EN selects a rotating-pointer arbiter;
// without it the lowest valid index wins and no pointer state exists.
module wb_rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
`ifdef WB_ROUND_ROBIN_EN
  input  logic               clk,
`endif
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic found_s;
  logic hit_s;

`ifdef WB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] grant_idx_s;
  logic [IDX_W-1:0] idx_s;
  int               sum_s;

  // First valid requester at or after ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    grant       = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    idx_s       = '0;
    sum_s       = 0;
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum_s       = int'(ptr_r) + k;
        sum_s       = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
        idx_s       = IDX_W'(sum_s);
        hit_s       = !found_s && req_valid[idx_s];
        grant[idx_s] = hit_s;
        grant_idx_s = hit_s ? idx_s : grant_idx_s;
        found_s     = found_s | hit_s;
      end
    end else begin
      grant = '0;
    end
  end

  // Pointer moves past the winner; idle cycles leave it in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (|grant) begin
      ptr_r <= (int'(grant_idx_s) == NUM_REQ - 1) ? '0 : grant_idx_s + 1'b1;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s    = !found_s && req_valid[i];
        grant[i] = hit_s;
        found_s  = found_s | hit_s;
      end
    end else begin
      grant = '0;
    end
  end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter with destination scoreboard and one-cycle write pipeline.
// Grant policy set by WB_ROUND_ROBIN_EN (see wb_rr_arbiter); default build is fixed priority.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          reserve_valid,
  input  logic [ADDR_WIDTH-1:0]         reserve_addr,
  output logic [(2**ADDR_WIDTH)-1:0]    busy,
  output logic                          rf_write,
  output logic [ADDR_WIDTH-1:0]         rf_addr,
  output logic [DATA_WIDTH-1:0]         rf_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [NUM_REGS-1:0] BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0]    grant_s;
  logic                  handshake_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_REGS-1:0]   clr_mask_s;
  logic [NUM_REGS-1:0]   set_mask_s;
  logic [NUM_REGS-1:0]   busy_next_s;
  logic [NUM_REGS-1:0]   busy_r;
  logic                  rf_write_r;
  logic [ADDR_WIDTH-1:0] rf_addr_r;
  logic [DATA_WIDTH-1:0] rf_data_r;

  wb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifdef WB_ROUND_ROBIN_EN
    .clk       (clk),
`endif
    .reset     (reset),
    .req_valid (req_valid),
    .grant     (grant_s)
  );

  assign req_ready   = grant_s;
  assign handshake_s = |(req_valid & grant_s);

  // One-hot grant selects the winning requester's slice.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_WIDTH{grant_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_s[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Set is applied after clear so a same-register reserve wins; x0 never tracked.
  assign clr_mask_s  = handshake_s ? (BIT0 << sel_addr_s) : '0;
  assign set_mask_s  = reserve_valid ? (BIT0 << reserve_addr) : '0;
  assign busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~BIT0;

  // Scoreboard and writeback output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r     <= '0;
      rf_write_r <= 1'b0;
      rf_addr_r  <= '0;
      rf_data_r  <= '0;
    end else begin
      busy_r <= busy_next_s;
      if (handshake_s) begin
        rf_write_r <= (sel_addr_s != '0);
        rf_addr_r  <= sel_addr_s;
        rf_data_r  <= sel_data_s;
      end else begin
        rf_write_r <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign rf_write = rf_write_r;
  assign rf_addr  = rf_addr_r;
  assign rf_data  = rf_data_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter; expectations follow WB_ROUND_ROBIN_EN.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              reserve_valid;
  logic [AW-1:0]     reserve_addr;
  logic [31:0]       busy;
  logic              rf_write;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NR-1:0] exp_rdy3 [4];
  logic [AW-1:0] exp_addr3 [4];
  logic [NR-1:0] exp_rdy2 [3];
  logic [AW-1:0] exp_addr2 [3];

  writeback_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .busy          (busy),
    .rf_write      (rf_write),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data)
  );

  always #5 clk = ~clk;

  task automatic check_equal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = 1'b1;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic idle();
    req_valid     = '0;
    reserve_valid = 1'b0;
    reserve_addr  = '0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef WB_ROUND_ROBIN_EN
    exp_rdy3  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr3 = '{5'd1, 5'd2, 5'd3, 5'd1};
    exp_rdy2  = '{3'b100, 3'b001, 3'b100};
    exp_addr2 = '{5'd3, 5'd1, 5'd3};
`else
    exp_rdy3  = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_addr3 = '{5'd1, 5'd1, 5'd1, 5'd1};
    exp_rdy2  = '{3'b001, 3'b001, 3'b001};
    exp_addr2 = '{5'd1, 5'd1, 5'd1};
`endif
    reset    = 1'b0;
    req_addr = '0;
    req_data = '0;
    idle();
    req_valid = 3'b111;
    #12;
    check_equal("reset_ready", req_ready, 3'b000);
    check_equal("reset_rf_write", rf_write, 1'b0);
    check_equal("reset_rf_addr", rf_addr, 5'd0);
    check_equal("reset_rf_data", rf_data, 32'h0);
    check_equal("reset_busy", busy, 32'h0);

    @(negedge clk);
    idle();
    reset = 1'b1;
    after_edge();
    check_equal("idle_rf_write", rf_write, 1'b0);

    // Single requester 1, addr 7
    @(negedge clk);
    set_req(REQ_LSU, 5'd7, 32'hDEADBEEF);
    #1 check_equal("lsu_ready", req_ready, 3'b010);
    after_edge();
    check_equal("lsu_rf_write", rf_write, 1'b1);
    check_equal("lsu_rf_addr", rf_addr, 5'd7);
    check_equal("lsu_rf_data", rf_data, 32'hDEADBEEF);

    // Write to x0 is accepted but dropped
    @(negedge clk);
    idle();
    set_req(REQ_ALU, 5'd0, 32'h1234);
    #1 check_equal("x0_ready", req_ready, 3'b001);
    after_edge();
    check_equal("x0_rf_write", rf_write, 1'b0);
    check_equal("x0_rf_addr", rf_addr, 5'd0);
    check_equal("x0_rf_data", rf_data, 32'h1234);

    @(negedge clk);
    idle();
    #1 check_equal("none_ready", req_ready, 3'b000);
    after_edge();
    check_equal("none_rf_write", rf_write, 1'b0);

    // Scoreboard
    @(negedge clk);
    reserve_valid = 1'b1;
    reserve_addr  = 5'd5;
    after_edge();
    check_equal("busy_set5", busy, 32'h0000_0020);
    @(negedge clk);
    set_req(REQ_CSR, 5'd5, 32'hAA);
    #1 check_equal("csr_ready", req_ready, 3'b100);
    after_edge();
    check_equal("busy_set_wins", busy, 32'h0000_0020);
    check_equal("csr_rf_write", rf_write, 1'b1);
    check_equal("csr_rf_addr", rf_addr, 5'd5);
    @(negedge clk);
    reserve_valid = 1'b0;
    after_edge();
    check_equal("busy_clear5", busy, 32'h0);
    @(negedge clk);
    idle();
    set_req(REQ_ALU, 5'd3, 32'h33);
    reserve_valid = 1'b1;
    reserve_addr  = 5'd9;
    after_edge();
    check_equal("busy_nonbusy_write", busy, 32'h0000_0200);
    check_equal("alu3_rf_addr", rf_addr, 5'd3);
    @(negedge clk);
    idle();
    reserve_valid = 1'b1;
    reserve_addr  = 5'd0;
    after_edge();
    check_equal("busy_x0_reserve", busy, 32'h0000_0200);

    // Reset mid-cycle after a handshake
    @(negedge clk);
    idle();
    set_req(REQ_LSU, 5'd7, 32'h5555);
    reserve_valid = 1'b1;
    reserve_addr  = 5'd4;
    after_edge();
    check_equal("pre_reset_rf_write", rf_write, 1'b1);
    check_equal("pre_reset_busy", busy, 32'h0000_0210);
    #2 reset = 1'b0;
    #1;
    check_equal("async_rf_write", rf_write, 1'b0);
    check_equal("async_rf_addr", rf_addr, 5'd0);
    check_equal("async_rf_data", rf_data, 32'h0);
    check_equal("async_busy", busy, 32'h0);
    check_equal("async_ready", req_ready, 3'b000);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 1'b1;
    after_edge();
    check_equal("post_reset_rf_write", rf_write, 1'b0);
    after_edge();
    check_equal("post_reset_rf_write2", rf_write, 1'b0);

    // All three requesters valid continuously
    @(negedge clk);
    set_req(REQ_ALU, 5'd1, 32'h101);
    set_req(REQ_LSU, 5'd2, 32'h102);
    set_req(REQ_CSR, 5'd3, 32'h103);
    for (int k = 0; k < 4; k++) begin
      #1 check_equal($sformatf("all3_ready_%0d", k), req_ready, exp_rdy3[k]);
      after_edge();
      check_equal($sformatf("all3_rf_addr_%0d", k), rf_addr, exp_addr3[k]);
      @(negedge clk);
    end

    // Requesters 0 and 2 valid
    req_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1 check_equal($sformatf("r02_ready_%0d", k), req_ready, exp_rdy2[k]);
      after_edge();
      check_equal($sformatf("r02_rf_addr_%0d", k), rf_addr, exp_addr2[k]);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of writeback requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination indices, requester i at slice i.
REQ-009 SHALL have port req_data  in  NUM_REQ*DATA_WIDTH  packed write data, requester i at slice i.
REQ-010 SHALL have port reserve_valid  in  1  issue stage reserves a destination register.
REQ-011 SHALL have port reserve_addr  in  ADDR_WIDTH  register being reserved.
REQ-012 SHALL have port busy  out  2**ADDR_WIDTH  scoreboard, bit r set while register r has a pending write.
REQ-013 SHALL have port rf_write  out  1  register-file write enable.
REQ-014 SHALL have port rf_addr  out  ADDR_WIDTH  register-file write index.
REQ-015 SHALL have port rf_data  out  DATA_WIDTH  register-file write data.

Function
REQ-016 SHALL complete a handshake for requester i in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-017 SHALL assert req_ready for exactly one valid requester when any req_valid is 1, and drive all req_ready to 0 otherwise; req_ready is combinational from req_valid and arbiter state.
REQ-018 SHALL register the accepted addr/data and drive rf_write/rf_addr/rf_data exactly one cycle after the handshake; rf_write is 0 in any cycle not preceded by a handshake.
REQ-019 SHALL accept a request with addr 0 normally but drive rf_write 0 on the following cycle (x0 writes dropped); rf_addr/rf_data still load.
REQ-020 SHALL, in round-robin mode, grant the first valid requester at or after pointer ptr (mod NUM_REQ), then set ptr to (granted+1) mod NUM_REQ; ptr is unchanged in cycles with no grant.
REQ-021 SHALL set busy[reserve_addr] on the edge following reserve_valid=1 when reserve_addr!=0.
REQ-022 SHALL clear busy[r] on the edge following a handshake with destination r.
REQ-023 SHALL let set win when reserve and clear target the same register in the same cycle.
REQ-024 SHALL hold busy[0] at 0 permanently.
REQ-025 SHALL not check busy before granting; a write to a non-busy register is performed and leaves busy unchanged.

Reset
REQ-026 SHALL, while reset=0, force rf_write=0, rf_addr=0, rf_data=0, busy=0, ptr=0 immediately, independent of clk.
REQ-027 SHALL discard a write registered but not yet presented when reset asserts; no rf_write after release until a new handshake.
REQ-028 SHALL drive req_ready all 0 while reset=0.

Configuration
REQ-029 SHALL, with WB_ROUND_ROBIN_EN defined, use round-robin grant per REQ-020.
REQ-030 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority (lowest valid index wins) and contain no ptr register; all other behaviour identical.

Structure
REQ-031 SHALL take NUM_REQ default and requester indices (REQ_ALU=0, REQ_LSU=1, REQ_CSR=2) from the shared core package.
REQ-032 SHALL place grant logic and ptr in one sub-module, wb_rr_arbiter; scoreboard and output register stay in writeback_arbiter.

Verification
REQ-033 SHALL cover: all three valid continuously with addr 1/2/3, round-robin -> grants 0,1,2,0 on consecutive cycles; rf_addr 1,2,3,1 one cycle later.
REQ-034 SHALL cover: req 1 valid alone, addr 7, data 0xDEADBEEF -> req_ready[1]=1 same cycle; next cycle rf_write=1, rf_addr=7, rf_data=0xDEADBEEF.
REQ-035 SHALL cover: req 0 writes addr 0 data 0x1234 -> req_ready[0]=1, next cycle rf_write=0.
REQ-036 SHALL cover: reserve addr 5, later handshake to 5 while reserve addr 5 same cycle -> busy[5] stays 1; reserve addr 0 -> busy[0]=0.
REQ-037 SHALL cover: reset=0 asserted mid-cycle after a handshake -> rf_write, busy, ptr 0 immediately; no write after release.
REQ-038 SHALL cover: WB_ROUND_ROBIN_EN undefined, req 0 and 2 always valid -> req 0 granted every cycle, req 2 never.
